// File: rtl/spi_reader_pkg.sv
// Shared definitions for the SPI frame reader: FSM state encoding and SPI mode constants.
package spi_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } state_e;

  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_frame_reader_if.sv
// SPI pin bundle between the frame reader (master) and the FPGA slave port.
interface spi_frame_reader_if;
  logic sclk;
  logic SPI_cs;
  logic SPI_RDY;
  logic processed_MISO;

  modport master (output sclk, output SPI_cs, input SPI_RDY, input processed_MISO);
  modport slave  (input sclk, input SPI_cs, output SPI_RDY, output processed_MISO);
endinterface

// File: rtl/spi_clk_gen.sv
// sclk divider for the frame reader: toggles every CLK_DIV cycles while enabled,
// idles at CPOL otherwise, and flags the cycle before each rising/falling sclk edge.
module spi_clk_gen
  import spi_reader_pkg::*;
#(
  parameter int CLK_DIV = 2
)(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("spi_clk_gen: CLK_DIV must be >= 1");
  end

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          toggle;

  always_comb begin
    toggle = en && (cnt_q == LAST);
    cnt_d  = '0;
    sclk_d = CPOL;
    if (en) begin
      cnt_d  = toggle ? '0 : cnt_q + 1'b1;
      sclk_d = toggle ? ~sclk_q : sclk_q;
    end
    rise_stb = toggle && (sclk_q == CPOL);
    fall_stb = toggle && (sclk_q != CPOL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= CPOL;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_frame_reader.sv
// SPI master reading NUM_CH x WORD_W sample frames from the localization FPGA.
// Optional RDY wait timeout enabled by defining SPI_READER_TIMEOUT_EN.
module spi_frame_reader
  import spi_reader_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int WORD_W      = 16,
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 4096
)(
  input  logic                      CLOCK_27M,
  input  logic                      rst,
  input  logic                      start,
  spi_frame_reader_if.master        spi,
  output logic [WORD_W-1:0]         sample_data,
  output logic [$clog2(NUM_CH)-1:0] sample_ch,
  output logic                      sample_valid,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      rdy_timeout
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("spi_frame_reader: CLK_DIV must be >= 1");
  end
  if (WORD_W < 2 || NUM_CH < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("spi_frame_reader: WORD_W and NUM_CH must be >= 2, TIMEOUT_CYC >= 1");
  end

  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW  = $clog2(WORD_W);
  localparam int CHW = $clog2(NUM_CH);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(WORD_W - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(NUM_CH - 1);

  state_e             state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [CHW-1:0]     ch_q, ch_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic [CHW-1:0]     sch_q, sch_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               cs_q, cs_d;
  logic [WORD_W-1:0]  shifted;
  logic               sclk_w, rise_stb, fall_stb, cap_stb;
  logic               tmo_hit;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (CLOCK_27M),
    .rst      (rst),
    .en       (state_q == SHIFT),
    .sclk     (sclk_w),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Capture at the end of the high phase so the slave gets a full half-period of setup.
  assign cap_stb = CPHA ? rise_stb : fall_stb;

`ifdef SPI_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_out_q;

  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT_RDY) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge CLOCK_27M) begin
    if (rst) begin
      tmo_q     <= '0;
      tmo_out_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      tmo_out_q <= tmo_hit;
    end
  end

  assign rdy_timeout = tmo_out_q;
`else
  assign rdy_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    shift_d = shift_q;
    data_d  = data_q;
    sch_d   = sch_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    tmo_hit = 1'b0;

    if (MSB_FIRST) shifted = {shift_q[WORD_W-2:0], spi.processed_MISO};
    else           shifted = {spi.processed_MISO, shift_q[WORD_W-1:1]};

    unique case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (spi.SPI_RDY) begin
          state_d = CS_SETUP;
          div_d   = '0;
          bit_d   = '0;
          ch_d    = '0;
        end
`ifdef SPI_READER_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
          tmo_hit = 1'b1;
        end
`endif
      end
      CS_SETUP, CS_HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = (state_q == CS_SETUP) ? SHIFT : DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cap_stb) begin
          shift_d = shifted;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            data_d  = shifted;
            sch_d   = ch_q;
            valid_d = 1'b1;
            if (ch_q == CH_LAST) begin
              ch_d    = '0;
              state_d = CS_HOLD;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cs_d = !(state_d inside {CS_SETUP, SHIFT, CS_HOLD});
  end

  always_ff @(posedge CLOCK_27M) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      ch_q    <= '0;
      shift_q <= '0;
      data_q  <= '0;
      sch_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      sch_q   <= sch_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
    end
  end

  assign spi.sclk     = sclk_w;
  assign spi.SPI_cs   = cs_q;
  assign sample_data  = data_q;
  assign sample_ch    = sch_q;
  assign sample_valid = valid_q;
  assign frame_done   = done_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_frame_reader.sv
// Directed bench for spi_frame_reader: table-driven frames plus hand sequences
// for ignored inputs, mid-frame reset, CLK_DIV=1 and (if enabled) RDY timeout.
module tb_spi_frame_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- DUT 0: defaults ----------------
  logic        start0 = 1'b0, rdy0 = 1'b0;
  logic [63:0] frm0 = '0;
  int          idx0 = 0;
  logic [15:0] data0;
  logic [1:0]  ch0;
  logic        valid0, done0, busy0, tmo0;

  spi_frame_reader_if if0 ();
  assign if0.SPI_RDY        = rdy0;
  assign if0.processed_MISO = (idx0 < 64) ? frm0[63 - idx0] : 1'b0;
  always @(negedge if0.sclk or posedge if0.SPI_cs)
    if (if0.SPI_cs) idx0 <= 0;
    else            idx0 <= idx0 + 1;

  spi_frame_reader #(.CLK_DIV(2), .WORD_W(16), .NUM_CH(4), .TIMEOUT_CYC(4096)) dut (
    .CLOCK_27M(clk), .rst(rst), .start(start0), .spi(if0),
    .sample_data(data0), .sample_ch(ch0), .sample_valid(valid0),
    .frame_done(done0), .busy(busy0), .rdy_timeout(tmo0)
  );

  int          v_cnt = 0, done_cnt = 0, cs_low = 0, fall_cnt = 0, tmo_cnt = 0;
  logic        prev_sclk = 1'b0;
  logic [15:0] v_data [0:127];
  logic [1:0]  v_ch   [0:127];

  always @(negedge clk) begin
    if (valid0 === 1'b1) begin
      if (v_cnt < 128) begin
        v_data[v_cnt] <= data0;
        v_ch[v_cnt]   <= ch0;
      end
      v_cnt <= v_cnt + 1;
    end
    if (done0 === 1'b1)      done_cnt <= done_cnt + 1;
    if (if0.SPI_cs === 1'b0) cs_low   <= cs_low + 1;
    if (tmo0 === 1'b1)       tmo_cnt  <= tmo_cnt + 1;
    if (prev_sclk === 1'b1 && if0.sclk === 1'b0) fall_cnt <= fall_cnt + 1;
    prev_sclk <= if0.sclk;
  end

  // ---------------- DUT 1: CLK_DIV = 1 ----------------
  logic        start1 = 1'b0, rdy1 = 1'b0;
  logic [63:0] frm1 = 64'h8001_8001_8001_8001;
  int          idx1 = 0;
  logic [15:0] data1;
  logic [1:0]  ch1;
  logic        valid1, done1, busy1, tmo1;

  spi_frame_reader_if if1 ();
  assign if1.SPI_RDY        = rdy1;
  assign if1.processed_MISO = (idx1 < 64) ? frm1[63 - idx1] : 1'b0;
  always @(negedge if1.sclk or posedge if1.SPI_cs)
    if (if1.SPI_cs) idx1 <= 0;
    else            idx1 <= idx1 + 1;

  spi_frame_reader #(.CLK_DIV(1), .WORD_W(16), .NUM_CH(4), .TIMEOUT_CYC(4096)) dut1 (
    .CLOCK_27M(clk), .rst(rst), .start(start1), .spi(if1),
    .sample_data(data1), .sample_ch(ch1), .sample_valid(valid1),
    .frame_done(done1), .busy(busy1), .rdy_timeout(tmo1)
  );

  int          v1_cnt = 0, done1_cnt = 0, cs1_low = 0, hi1_cnt = 0;
  logic [15:0] v1_data [0:7];
  logic [1:0]  v1_ch   [0:7];

  always @(negedge clk) begin
    if (valid1 === 1'b1) begin
      if (v1_cnt < 8) begin
        v1_data[v1_cnt] <= data1;
        v1_ch[v1_cnt]   <= ch1;
      end
      v1_cnt <= v1_cnt + 1;
    end
    if (done1 === 1'b1)      done1_cnt <= done1_cnt + 1;
    if (if1.SPI_cs === 1'b0) cs1_low   <= cs1_low + 1;
    if (if1.sclk === 1'b1)   hi1_cnt   <= hi1_cnt + 1;
  end

`ifdef SPI_READER_TIMEOUT_EN
  // ---------------- DUT 2: short RDY timeout ----------------
  logic        start2 = 1'b0;
  logic [15:0] data2;
  logic [1:0]  ch2;
  logic        valid2, done2, busy2, tmo2;

  spi_frame_reader_if if2 ();
  assign if2.SPI_RDY        = 1'b0;
  assign if2.processed_MISO = 1'b0;

  spi_frame_reader #(.CLK_DIV(2), .WORD_W(16), .NUM_CH(4), .TIMEOUT_CYC(16)) dut2 (
    .CLOCK_27M(clk), .rst(rst), .start(start2), .spi(if2),
    .sample_data(data2), .sample_ch(ch2), .sample_valid(valid2),
    .frame_done(done2), .busy(busy2), .rdy_timeout(tmo2)
  );

  int tmo2_cnt = 0, cs2_low = 0;
  always @(negedge clk) begin
    if (tmo2 === 1'b1)       tmo2_cnt <= tmo2_cnt + 1;
    if (if2.SPI_cs === 1'b0) cs2_low  <= cs2_low + 1;
  end
`endif

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0]       frame;
    int                rdy_delay;
    logic [0:3][15:0]  exp_w;
    int                exp_cs_low;
  } vec_t;

  vec_t vecs [3];

  task automatic wait_done0(input int db, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (done_cnt > db) got = 1'b1;
      else tick();
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic check_words(input int vb, input logic [0:3][15:0] w, input string tag);
    chk({tag, "_nvalid"}, 64'(v_cnt - vb), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (vb + k < 128) begin
        chk($sformatf("%s_data%0d", tag, k), 64'(v_data[vb + k]), 64'(w[k]));
        chk($sformatf("%s_ch%0d", tag, k), 64'(v_ch[vb + k]), 64'(k));
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int vb, db, cb, wait_bad;
    frm0 = v.frame;
    rdy0 = (v.rdy_delay == 0);
    vb = v_cnt; db = done_cnt; cb = cs_low;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk({tag, "_busy"}, 64'(busy0), 64'd1);
    chk({tag, "_cs_hi_wait"}, 64'(if0.SPI_cs), 64'd1);
    if (v.rdy_delay == 0) begin
      tick();
      chk({tag, "_cs_lat"}, 64'(if0.SPI_cs), 64'd0);
    end else begin
      wait_bad = 0;
      for (int i = 0; i < v.rdy_delay; i++) begin
        if (busy0 !== 1'b1 || if0.SPI_cs !== 1'b1) wait_bad++;
        tick();
      end
      chk({tag, "_wait_busy"}, 64'(wait_bad), 64'd0);
      rdy0 = 1'b1;
      tick();
      chk({tag, "_cs_after_rdy"}, 64'(if0.SPI_cs), 64'd0);
    end
    wait_done0(db, tag);
    tick(); tick();
    check_words(vb, v.exp_w, tag);
    chk({tag, "_cs_low"}, 64'(cs_low - cb), 64'(v.exp_cs_low));
    chk({tag, "_ndone"}, 64'(done_cnt - db), 64'd1);
    chk({tag, "_idle"}, 64'(busy0), 64'd0);
  endtask

  initial begin
    int vb, db, fb, idle_bad;
    bit got;

    vecs[0] = '{frame: 64'hA5A5_1234_0000_FFFF, rdy_delay: 0,
                exp_w: {16'hA5A5, 16'h1234, 16'h0000, 16'hFFFF}, exp_cs_low: 260};
    vecs[1] = '{frame: 64'hDEAD_BEEF_0F0F_5A5A, rdy_delay: 50,
                exp_w: {16'hDEAD, 16'hBEEF, 16'h0F0F, 16'h5A5A}, exp_cs_low: 260};
    vecs[2] = '{frame: 64'h0001_8000_7FFE_C3C3, rdy_delay: 0,
                exp_w: {16'h0001, 16'h8000, 16'h7FFE, 16'hC3C3}, exp_cs_low: 260};

    // reset values
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_sclk",  64'(if0.sclk),   64'd0);
    chk("rst_cs",    64'(if0.SPI_cs), 64'd1);
    chk("rst_data",  64'(data0),      64'd0);
    chk("rst_ch",    64'(ch0),        64'd0);
    chk("rst_valid", 64'(valid0),     64'd0);
    chk("rst_done",  64'(done0),      64'd0);
    chk("rst_busy",  64'(busy0),      64'd0);
    chk("rst_tmo",   64'(tmo0),       64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // start re-pulsed and RDY dropped mid-frame: one frame only, no queued request
    frm0 = 64'h1357_9BDF_2468_ACE0;
    rdy0 = 1'b1;
    vb = v_cnt; db = done_cnt;
    start0 = 1'b1; tick(); start0 = 1'b0;
    repeat (100) tick();
    start0 = 1'b1; rdy0 = 1'b0; tick(); start0 = 1'b0;
    wait_done0(db, "ign");
    tick(); tick();
    check_words(vb, {16'h1357, 16'h9BDF, 16'h2468, 16'hACE0}, "ign");
    idle_bad = 0;
    repeat (60) begin
      if (busy0 !== 1'b0 || if0.SPI_cs !== 1'b1) idle_bad++;
      tick();
    end
    chk("ign_stays_idle", 64'(idle_bad), 64'd0);
    chk("ign_ndone", 64'(done_cnt - db), 64'd1);

    // reset after 20 bits
    frm0 = 64'hFEDC_BA98_7654_3210;
    rdy0 = 1'b1;
    fb = fall_cnt;
    start0 = 1'b1; tick(); start0 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      if (fall_cnt - fb >= 20) got = 1'b1;
      else tick();
    end
    chk("mid_20bits", 64'(got), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_cs",   64'(if0.SPI_cs), 64'd1);
    chk("mid_sclk", 64'(if0.sclk),   64'd0);
    chk("mid_data", 64'(data0),      64'd0);
    chk("mid_ch",   64'(ch0),        64'd0);
    chk("mid_busy", 64'(busy0),      64'd0);
    rst = 1'b0;
    vb = v_cnt; db = done_cnt;
    repeat (300) tick();
    chk("mid_no_valid", 64'(v_cnt - vb),    64'd0);
    chk("mid_no_done",  64'(done_cnt - db), 64'd0);
    run_frame(vecs[0], "post_rst");

    // CLK_DIV = 1
    rdy1 = 1'b1;
    vb = v1_cnt; db = done1_cnt; fb = cs1_low; idle_bad = hi1_cnt;
    start1 = 1'b1; tick(); start1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      if (done1_cnt > db) got = 1'b1;
      else tick();
    end
    chk("div1_done_seen", 64'(got), 64'd1);
    tick(); tick();
    chk("div1_nvalid", 64'(v1_cnt - vb), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (vb + k < 8) begin
        chk($sformatf("div1_data%0d", k), 64'(v1_data[vb + k]), 64'h8001);
        chk($sformatf("div1_ch%0d", k),   64'(v1_ch[vb + k]),   64'(k));
      end
    end
    chk("div1_cs_low",  64'(cs1_low - fb),         64'd130);
    chk("div1_sclk_hi", 64'(hi1_cnt - idle_bad),   64'd64);
    chk("div1_ndone",   64'(done1_cnt - db),       64'd1);

`ifdef SPI_READER_TIMEOUT_EN
    start2 = 1'b1; tick(); start2 = 1'b0;
    chk("tmo_busy", 64'(busy2), 64'd1);
    repeat (40) tick();
    chk("tmo_pulses", 64'(tmo2_cnt), 64'd1);
    chk("tmo_cs",     64'(cs2_low),  64'd0);
    chk("tmo_idle",   64'(busy2),    64'd0);
`endif

    chk("dflt_no_timeout", 64'(tmo_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
